// File: rtl/reg_access_arbiter_if.sv
// rtl/reg_access_arbiter_if.sv - requester ports and register bank port of reg_access_arbiter
interface reg_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int ADDR_W = 8
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [BE_W-1:0]   a_be;
  logic              a_ack;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [BE_W-1:0]   b_be;
  logic              b_ack;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wr_data;
  logic [DATA_W-1:0] bank_enb;
  logic [DATA_W-1:0] bank_rd_data;

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_be,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_be,
    input  b_ack, b_err, b_rdata,
    input  bank_addr, bank_wr_data, bank_enb,
    output bank_rd_data
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_be,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    output b_ack, b_err, b_rdata,
    output bank_addr, bank_wr_data, bank_enb,
    input  bank_rd_data
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - round-robin two-port arbiter onto the SD host register bank
module reg_access_arbiter #(
  parameter int DATA_W   = 32,
  parameter int BE_W     = DATA_W / 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 64
) (
  input logic                 clk,
  input logic                 reset,
  reg_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

  state_t            state, state_nxt;
  logic              last_grant;  // 0 = port A, 1 = port B
  logic              sel;
  logic              grant_a, grant_b;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic [DATA_W-1:0] mask;
  logic              in_range;

  assign in_range          = ({1'b0, addr_q} < LIMIT);
  assign bus.bank_addr     = addr_q;
  assign bus.bank_wr_data  = wdata_q;
  assign bus.a_rdata       = a_rdata_q;
  assign bus.b_rdata       = b_rdata_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = {8{be_q[i]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    bus.bank_enb = '0;
    bus.a_ack    = 1'b0;
    bus.a_err    = 1'b0;
    bus.b_ack    = 1'b0;
    bus.b_err    = 1'b0;
    case (state)
      IDLE: begin
        // On contention the port that did not win last time gets the bank.
        grant_a = bus.a_req && (!bus.b_req || last_grant);
        grant_b = bus.b_req && (!bus.a_req || !last_grant);
        if (grant_a || grant_b) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q && in_range) begin
          bus.bank_enb = mask;
        end
        state_nxt = DONE;
      end
      DONE: begin
        bus.a_ack = !sel;
        bus.a_err = !sel && !in_range;
        bus.b_ack = sel;
        bus.b_err = sel && !in_range;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      if (grant_a) begin
        sel        <= 1'b0;
        last_grant <= 1'b0;
        we_q       <= bus.a_we;
        be_q       <= bus.a_be;
        addr_q     <= bus.a_addr;
        wdata_q    <= bus.a_wdata;
      end else if (grant_b) begin
        sel        <= 1'b1;
        last_grant <= 1'b1;
        we_q       <= bus.b_we;
        be_q       <= bus.b_be;
        addr_q     <= bus.b_addr;
        wdata_q    <= bus.b_wdata;
      end
      if (state == ACCESS && !we_q) begin
        if (!sel) begin
          a_rdata_q <= in_range ? bus.bank_rd_data : '0;
        end else begin
          b_rdata_q <= in_range ? bus.bank_rd_data : '0;
        end
      end
    end
  end
endmodule
